left_shift: RTL and testbench
=============================

# left_shift

Parameterised logical left shifter with a registered output, driving the board LED bank from the switch inputs. `sw` is shifted left by `shamt` positions, zero-filling from the LSB, and the result is registered onto `led` one clock later. It sits between the switch/button input synchroniser and the LED outputs in the top-level demo design.

## Interface
- `WIDTH`, default 4: data width of `sw` and `led`; must be ≥ 2.
- `SHAMT_W`, default `$clog2(WIDTH)` (2): width of `shamt`.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `sw`  input  WIDTH: data to be shifted.
- `shamt`  input  SHAMT_W: shift amount, unsigned.
- `led`  output  WIDTH: registered shift result.
- `ovf`  output  1: present only when `LEFT_SHIFT_OVF_EN` is defined. Registered flag showing that at least one '1' bit was shifted out.

## Operation
- Next result is `(sw << shamt)` truncated to WIDTH bits.
  - Shift is logical: vacated LSBs are 0 and MSBs shifted out are discarded.
  - There is no rotate and no sign extension.
- If `shamt` ≥ WIDTH, which is possible only when WIDTH is not a power of two, the result is all zeros.
- The shift is built as log2 stages: stage k shifts by 2^k when `shamt[k]` = 1, otherwise passes through unchanged.
- The block is purely data-path. It has no FSM and no handshake, and samples inputs every cycle.
- Reference values for WIDTH = 4:
  - `sw` = 0101, `shamt` 0/1/2/3 gives 0101 / 1010 / 0100 / 1000.
  - `sw` = 1010, `shamt` 0/1/2/3 gives 1010 / 0100 / 1000 / 0000.

## Timing
- Latency is 1 cycle: `led` at edge n+1 reflects `sw`/`shamt` sampled at edge n.
- Throughput is one result per cycle. Back-to-back input changes each produce their own result.
- Reset behaviour:
  - `rst_n` low forces `led` = 0 (and `ovf` = 0) immediately, independent of `clk`.
  - Outputs hold 0 while `rst_n` is low.
  - The first valid result appears on the first rising edge after `rst_n` deasserts.
- Reset mid-operation discards the in-flight result. There is no recovery state.
- Inputs must be stable setup/hold around the `clk` rising edge. Asynchronous switch inputs are synchronised upstream, not in this block.

## Configuration
- `LEFT_SHIFT_OVF_EN` defined:
  - Adds the `ovf` output port.
  - `ovf` is registered with the same 1-cycle latency and reset value 0 as `led`.
  - `ovf` = 1 when any bit of `sw[WIDTH-1 : WIDTH-shamt]` is 1; it is 0 when `shamt` = 0.
- `LEFT_SHIFT_OVF_EN` undefined: no `ovf` port and no overflow logic. `led` behaviour is identical in both builds.

## Structure
- Package `left_shift_pkg` holds:
  - the default `WIDTH` constant;
  - the derived `SHAMT_W` constant;
  - typedefs `data_t` (logic [WIDTH-1:0]) and `shamt_t` (logic [SHAMT_W-1:0]).
- Sub-module `left_shift_barrel` is the combinational log-stage shifter. It also computes the overflow when the macro is enabled.
- Top `left_shift` holds only the output registers with asynchronous reset.

## Test plan
- Reset: assert `rst_n` = 0 with `sw` = 1111, `shamt` = 01 → `led` = 0000 immediately and throughout reset. After release, the first edge gives `led` = 1110.
- Sweep A: `sw` = 0101, `shamt` stepping 00, 01, 10, 11, one value per cycle → `led` = 0101, 1010, 0100, 1000, each one cycle after its input.
- Sweep B: `sw` = 1010, `shamt` stepping 00, 01, 10, 11 → `led` = 1010, 0100, 1000, 0000.
- Overflow (`LEFT_SHIFT_OVF_EN` defined):
  - `sw` = 0101: `shamt` = 01 gives `ovf` = 0; `shamt` = 10 gives `ovf` = 1.
  - `sw` = 1010: `shamt` = 01 gives `ovf` = 1; `shamt` = 00 gives `ovf` = 0.
- Mid-stream reset: while Sweep A runs, pulse `rst_n` low between clock edges → `led` drops to 0000 asynchronously. After release it resumes the correct value on the next edge.
- Exhaustive check: all 16 `sw` × 4 `shamt` combinations, compared against a `(sw << shamt) & 4'hF` model at 1-cycle latency → zero mismatches.

Source files
------------

// File: rtl/left_shift_pkg.sv
// left_shift_pkg: default widths and data types shared by the left_shift slice
package left_shift_pkg;
    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_SHAMT_W = $clog2(DEFAULT_WIDTH);

    typedef logic [DEFAULT_WIDTH-1:0]   data_t;
    typedef logic [DEFAULT_SHAMT_W-1:0] shamt_t;
endpackage

// File: rtl/left_shift_if.sv
// left_shift_if: switch/shift-amount inputs and LED outputs of the shifter
// ovf is carried only when LEFT_SHIFT_OVF_EN is defined
interface left_shift_if
    import left_shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0]   sw;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   led;
`ifdef LEFT_SHIFT_OVF_EN
    logic               ovf;

    modport master (output sw, output shamt, input led, input ovf);
    modport slave  (input sw, input shamt, output led, output ovf);
`else
    modport master (output sw, output shamt, input led);
    modport slave  (input sw, input shamt, output led);
`endif
endinterface

// File: rtl/left_shift_barrel.sv
// left_shift_barrel: combinational log-stage logical left shifter
// overflow detection is built only when LEFT_SHIFT_OVF_EN is defined
module left_shift_barrel
    import left_shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
)(
    input  logic [WIDTH-1:0]   i_sw,
    input  logic [SHAMT_W-1:0] i_shamt,
`ifdef LEFT_SHIFT_OVF_EN
    output logic               o_ovf,
`endif
    output logic [WIDTH-1:0]   o_led
);
    logic [WIDTH-1:0] w_stage [SHAMT_W+1];

    assign w_stage[0] = i_sw;

    // stages accumulate, so an amount of WIDTH or more zero-fills completely
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        assign w_stage[k+1] = i_shamt[k] ? w_stage[k] << (2**k) : w_stage[k];
    end

    assign o_led = w_stage[SHAMT_W];

`ifdef LEFT_SHIFT_OVF_EN
    // the bits that survive are exactly those under the right-shifted all-ones mask
    assign o_ovf = |(i_sw & ~({WIDTH{1'b1}} >> i_shamt));
`endif
endmodule

// File: rtl/left_shift.sv
// left_shift: registered logical left shift of the switch bank onto the LEDs
// optional registered overflow flag when LEFT_SHIFT_OVF_EN is defined
module left_shift
    import left_shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
)(
    input  logic       clk,
    input  logic       rst_n,
    left_shift_if.slave bus
);
    logic [WIDTH-1:0] w_led;
    logic [WIDTH-1:0] r_led;

`ifdef LEFT_SHIFT_OVF_EN
    logic w_ovf;
    logic r_ovf;
`endif

    left_shift_barrel #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_barrel (
        .i_sw    (bus.sw),
        .i_shamt (bus.shamt),
`ifdef LEFT_SHIFT_OVF_EN
        .o_ovf   (w_ovf),
`endif
        .o_led   (w_led)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_led <= '0;
        else
            r_led <= w_led;
    end

    assign bus.led = r_led;

`ifdef LEFT_SHIFT_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else
            r_ovf <= w_ovf;
    end

    assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_left_shift.sv
// tb_left_shift: scoreboard bench for left_shift (WIDTH 4); covers ovf when LEFT_SHIFT_OVF_EN is defined
module tb_left_shift;
    import left_shift_pkg::*;

    typedef struct {
        data_t led;
        logic  ovf;
        string tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];

    left_shift_if #(.WIDTH(4), .SHAMT_W(2)) bus();

    left_shift #(.WIDTH(4), .SHAMT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic dut_ovf();
`ifdef LEFT_SHIFT_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(string tag, data_t led, logic ovf, data_t exp_led, logic exp_ovf);
        n_vec++;
`ifdef LEFT_SHIFT_OVF_EN
        if (led !== exp_led || ovf !== exp_ovf) begin
`else
        if (led !== exp_led) begin
`endif
            n_bad++;
            $display("FAIL %s: led=%b ovf=%b, expected led=%b ovf=%b", tag, led, ovf, exp_led, exp_ovf);
        end
    endtask

    task automatic push(string tag, data_t led, logic ovf);
        exp_t e;
        e.led = led;
        e.ovf = ovf;
        e.tag = tag;
        q.push_back(e);
    endtask

    // inputs change on the falling edge; the result is due after the next rising edge
    task automatic apply(string tag, data_t sw, shamt_t sh, data_t led, logic ovf);
        @(negedge clk);
        bus.sw    = sw;
        bus.shamt = sh;
        push(tag, led, ovf);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, bus.led, dut_ovf(), e.led, e.ovf);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m;
        logic o;
        bus.sw    = 4'b1111;
        bus.shamt = 2'b01;
        #1 rst_n = 1'b0;
        #1 check("reset_async", bus.led, dut_ovf(), 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", bus.led, dut_ovf(), 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push("reset_release", 4'b1110, 1'b1);
        @(posedge clk);

        apply("sweepA_sh0", 4'b0101, 2'd0, 4'b0101, 1'b0);
        apply("sweepA_sh1", 4'b0101, 2'd1, 4'b1010, 1'b0);
        apply("sweepA_sh2", 4'b0101, 2'd2, 4'b0100, 1'b1);
        apply("sweepA_sh3", 4'b0101, 2'd3, 4'b1000, 1'b1);

        apply("sweepB_sh0", 4'b1010, 2'd0, 4'b1010, 1'b0);
        apply("sweepB_sh1", 4'b1010, 2'd1, 4'b0100, 1'b1);
        apply("sweepB_sh2", 4'b1010, 2'd2, 4'b1000, 1'b1);
        apply("sweepB_sh3", 4'b1010, 2'd3, 4'b0000, 1'b1);

        apply("mid_sh0", 4'b0101, 2'd0, 4'b0101, 1'b0);
        apply("mid_sh1", 4'b0101, 2'd1, 4'b1010, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("mid_reset", bus.led, dut_ovf(), 4'b0000, 1'b0);
        #1 rst_n = 1'b1;
        check("mid_release", bus.led, dut_ovf(), 4'b0000, 1'b0);
        apply("mid_sh2", 4'b0101, 2'd2, 4'b0100, 1'b1);
        apply("mid_sh3", 4'b0101, 2'd3, 4'b1000, 1'b1);

        apply("edge_ones_sh3", 4'b1111, 2'd3, 4'b1000, 1'b1);
        apply("edge_lsb_sh3", 4'b0001, 2'd3, 4'b1000, 1'b0);
        apply("edge_msb_sh1", 4'b1000, 2'd1, 4'b0000, 1'b1);

        for (int s = 0; s < 16; s++) begin
            for (int h = 0; h < 4; h++) begin
                m = (s << h) & 15;
                o = (h != 0) && ((s >> (4 - h)) != 0);
                apply($sformatf("exh_sw%0d_sh%0d", s, h), data_t'(s), shamt_t'(h), data_t'(m), o);
            end
        end

        @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
